// File: rtl/mdio_master_pkg.sv
// Shared MDIO definitions: frame field constants, bit positions, FSM
// state encoding and the frame builder used at request acceptance.
package mdio_master_pkg;

    // Frame field constants
    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;

    // Write turnaround is driven as 10. On a read the master releases the
    // line, so the TA and data slots are filled with ones. That keeps
    // mdio_o at 1 while mdio_oe is low.
    localparam logic [1:0]  MDIO_TA_WR   = 2'b10;
    localparam logic [1:0]  MDIO_TA_IDLE = 2'b11;
    localparam logic [15:0] MDIO_DATA_IDLE = 16'hFFFF;

    // Frame geometry. Bit positions are 6-bit to match the bit counter.
    localparam int         MDIO_FRAME_BITS = 64;
    localparam logic [5:0] MDIO_PRE_BITS   = 6'd32;
    localparam logic [5:0] MDIO_TA_FIRST   = 6'd46;
    localparam logic [5:0] MDIO_DATA_FIRST = 6'd48;
    localparam logic [5:0] MDIO_LAST_BIT   = 6'(MDIO_FRAME_BITS - 1);

    // Master FSM state encoding (3-bit)
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_HDR  = 3'd2,
        ST_TA   = 3'd3,
        ST_DATA = 3'd4,
        ST_DONE = 3'd5
    } mdioState_e;

    // Build the whole 64-bit frame. Bit 0 of the frame is bit 63 of the
    // result, so the frame shifts out MSB first.
    function automatic logic [63:0] buildFrame(
        input logic        isRead,
        input logic [4:0]  phyAddr,
        input logic [4:0]  regAddr,
        input logic [15:0] data
    );
        logic [1:0]  op;
        logic [1:0]  ta;
        logic [15:0] payload;
        op      = isRead ? MDIO_OP_RD : MDIO_OP_WR;
        ta      = isRead ? MDIO_TA_IDLE : MDIO_TA_WR;
        payload = isRead ? MDIO_DATA_IDLE : data;
        return {32'hFFFF_FFFF, MDIO_ST, op, phyAddr, regAddr, ta, payload};
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: CLK_DIV clk cycles low, then CLK_DIV cycles high.
// When it is disabled, it sits with mdc=0 and the divider at zero, so each
// frame starts phase-aligned.
module mdio_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic mdc,
    output logic fallStrobe,
    output logic riseStrobe
);

    localparam int                CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             phaseEnd;

    // High on the last clk cycle of the current MDC half-period
    assign phaseEnd = enable && (cnt == CNT_LAST);

    // The edge that ends this cycle starts a new low phase (mdc 1->0)
    assign fallStrobe = phaseEnd && mdc;

    // The edge that ends this cycle is the mdc 0->1 transition
    assign riseStrobe = phaseEnd && !mdc;

    // Divider counter and MDC toggle. Both are held at zero while disabled.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (phaseEnd) begin
            cnt <= '0;
            mdc <= ~mdc;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO management master. It takes one write or read request
// and serialises the 64-bit frame on MDC/MDIO. A read returns its data
// with a one-cycle rd_valid strobe.
//
// Request handshake: wr_en/rd_en act as valid and !busy acts as ready.
// A request is taken on any rising edge where busy is low and either
// enable is high (a write wins over a read). Requests made while busy is
// high are dropped, not queued. rd_valid is a one-cycle push with no
// backpressure.
module mdio_master
    import mdio_master_pkg::*;
#(
    parameter int         CLK_DIV  = 4,
    parameter logic [4:0] PHY_ADDR = 5'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [4:0]  reg_addr,
    input  logic [15:0] wr_data,
    output logic        busy,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i,
    output mdioState_e  state
);

    logic        isRead;
    logic [62:0] txShift;      // frame bits still to send; the bit on the wire lives in mdio_o
    logic [15:0] rxShift;
    logic [5:0]  bitCnt;
    logic [5:0]  nextBit;
    logic [63:0] acceptFrame;
    logic        clkEnable;
    logic        mdcFall;
    logic        mdcRise;

    // MDC runs only while frame bits are on the wire
    assign clkEnable = (state != ST_IDLE) && (state != ST_DONE);

    assign nextBit = bitCnt + 6'd1;

    // Frame image for the request being accepted this cycle
    assign acceptFrame = buildFrame(!wr_en, PHY_ADDR, reg_addr, wr_data);

    mdio_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clkGen (
        .clk       (clk),
        .reset     (reset),
        .enable    (clkEnable),
        .mdc       (mdc),
        .fallStrobe(mdcFall),
        .riseStrobe(mdcRise)
    );

    // Frame FSM with TX/RX shift registers, bit counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 16'h0000;
            mdio_o   <= 1'b1;
            mdio_oe  <= 1'b0;
            isRead   <= 1'b0;
            txShift  <= '1;
            rxShift  <= 16'h0000;
            bitCnt   <= 6'd0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_en || rd_en) begin
                        isRead  <= !wr_en;
                        mdio_o  <= acceptFrame[63];
                        txShift <= acceptFrame[62:0];
                        mdio_oe <= 1'b1;
                        bitCnt  <= 6'd0;
                        busy    <= 1'b1;
                        state   <= ST_PRE;
                    end
                end

                ST_PRE, ST_HDR, ST_TA, ST_DATA: begin
                    // Read data is captured MSB first on each mdc rising edge of the data field
                    if (mdcRise && (state == ST_DATA)) begin
                        rxShift <= {rxShift[14:0], mdio_i};
                    end
                    // Everything else advances only at the start of a new low phase
                    if (mdcFall) begin
                        if (bitCnt == MDIO_LAST_BIT) begin
                            mdio_oe <= 1'b0;
                            mdio_o  <= 1'b1;
                            state   <= ST_DONE;
                            if (isRead) begin
                                rd_data  <= rxShift;
                                rd_valid <= 1'b1;
                            end
                        end else begin
                            bitCnt  <= nextBit;
                            mdio_o  <= txShift[62];
                            txShift <= {txShift[61:0], 1'b1};
                            // On a read the line is released from the TA field onwards
                            mdio_oe <= !(isRead && (nextBit >= MDIO_TA_FIRST));
                            if (nextBit == MDIO_PRE_BITS) begin
                                state <= ST_HDR;
                            end else if (nextBit == MDIO_TA_FIRST) begin
                                state <= ST_TA;
                            end else if (nextBit == MDIO_DATA_FIRST) begin
                                state <= ST_DATA;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    busy   <= 1'b0;
                    bitCnt <= 6'd0;
                    state  <= ST_IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    mdio_oe <= 1'b0;
                    mdio_o  <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
